// File: rtl/ss_fifo_sync_if.sv
// SS valid/ready stream interface used on both sides of ss_fifo_sync.
// The master drives valid/data/last and samples ready; the slave does the reverse.
interface ss_fifo_sync_if #(
  parameter int DATA_W = 8
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/ss_fifo_sync.sv
// ss_fifo_sync: synchronous first-word-fall-through FIFO for the SS stream.
// Pointers carry one extra MSB so that full and empty can be told apart.
// in.ready and almost_full are registered; out.valid comes from registered
// state only, so there is no combinational path from out.ready to in.ready.
//
// Optional feature: define SS_FIFO_PKT_MODE_EN for store-and-forward packet
// mode, where out.valid waits for a complete packet (or a full FIFO, which
// lets packets longer than the FIFO stream through cut-through).
module ss_fifo_sync #(
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_LVL = DEPTH - 2,
  parameter int DATA_W          = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ss_fifo_sync_if.slave              in_i,
  ss_fifo_sync_if.master             out_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       almost_full_o
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              inReady_q, inReady_d;
  logic              almostFull_q, almostFull_d;
  logic [DATA_W:0]   mem_q [DEPTH];

  logic              empty;
  logic              full;
  logic              fullNext;
  logic              outValid;
  logic              wrEn;
  logic              rdEn;
  logic [DATA_W:0]   headEntry;

`ifdef SS_FIFO_PKT_MODE_EN
  logic [LVL_W-1:0]  pktCnt_q, pktCnt_d;
`endif

  // Full/empty decode, head-of-queue view and the two handshakes.
  always_comb begin
    empty     = (wrPtr_q == rdPtr_q);
    full      = (wrPtr_q[ADDR_W-1:0] == rdPtr_q[ADDR_W-1:0]) &&
                (wrPtr_q[ADDR_W] != rdPtr_q[ADDR_W]);
    headEntry = mem_q[rdPtr_q[ADDR_W-1:0]];
`ifdef SS_FIFO_PKT_MODE_EN
    outValid  = !empty && ((pktCnt_q != '0) || full);
`else
    outValid  = !empty;
`endif
    wrEn      = in_i.valid && inReady_q;
    rdEn      = outValid && out_o.ready;
  end

  assign out_o.valid   = outValid;
  assign out_o.data    = headEntry[DATA_W-1:0];
  assign out_o.last    = headEntry[DATA_W];
  assign in_i.ready    = inReady_q;
  assign level_o       = level_q;
  assign almost_full_o = almostFull_q;

  // Next pointers, level and the registered flags derived from them.
  always_comb begin
    wrPtr_d = wrPtr_q + PTR_W'(wrEn);
    rdPtr_d = rdPtr_q + PTR_W'(rdEn);
    level_d = level_q;
    case ({wrEn, rdEn})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    fullNext     = (wrPtr_d[ADDR_W-1:0] == rdPtr_d[ADDR_W-1:0]) &&
                   (wrPtr_d[ADDR_W] != rdPtr_d[ADDR_W]);
    inReady_d    = !fullNext;
    almostFull_d = (level_d >= LVL_W'(ALMOST_FULL_LVL));
  end

  // Pointer, level and flag registers; reset discards every stored word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      level_q      <= '0;
      inReady_q    <= 1'b0;
      almostFull_q <= 1'b0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      level_q      <= level_d;
      inReady_q    <= inReady_d;
      almostFull_q <= almostFull_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem_q[wrPtr_q[ADDR_W-1:0]] <= {in_i.last, in_i.data};
    end
  end

`ifdef SS_FIFO_PKT_MODE_EN
  // Count of complete packets held; a last written and read together cancel.
  always_comb begin
    pktCnt_d = pktCnt_q;
    case ({wrEn && in_i.last, rdEn && headEntry[DATA_W]})
      2'b10:   pktCnt_d = pktCnt_q + LVL_W'(1);
      2'b01:   pktCnt_d = pktCnt_q - LVL_W'(1);
      default: pktCnt_d = pktCnt_q;
    endcase
  end

  // Packet counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pktCnt_q <= '0;
    end else begin
      pktCnt_q <= pktCnt_d;
    end
  end
`endif

endmodule
